// File: rtl/slc3_fetch_ctrl_if.sv
// Control bundle between the SLC-3 fetch sequencer and the datapath/memory.
// master = sequencer side, slave = datapath/button side.
interface slc3_fetch_ctrl_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;

  logic       LD_MAR;
  logic       LD_MDR;
  logic       LD_IR;
  logic       LD_PC;
  logic       LD_LED;

  logic       GatePC;
  logic       GateMDR;
  logic       GateALU;
  logic       GateMARMUX;

  logic [1:0] PCMUX;
  logic       MIO_EN;
  logic       Mem_OE;
  logic       Mem_WE;
  logic [2:0] State_o;

  modport master (
    input  Run, Continue, Opcode,
    output LD_MAR, LD_MDR, LD_IR, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, MIO_EN, Mem_OE, Mem_WE, State_o
  );

  modport slave (
    output Run, Continue, Opcode,
    input  LD_MAR, LD_MDR, LD_IR, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, MIO_EN, Mem_OE, Mem_WE, State_o
  );
endinterface

// File: rtl/slc3_fetch_ctrl.sv
// SLC-3 fetch/pause sequencer: Moore FSM driving datapath loads, bus gates
// and SRAM strobes, with a fixed SRAM read wait and button-stepped pausing.
module slc3_fetch_ctrl #(
  parameter int unsigned MEM_WAIT    = 2,     // 1..15 cycles of Mem_OE low
  parameter bit          PAUSE_EVERY = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  slc3_fetch_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    S18    = 3'd1,
    S33    = 3'd2,
    S35    = 3'd3,
    PAUSE1 = 3'd4,
    PAUSE2 = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);
  localparam logic [3:0] OP_PAUSE  = 4'b1101;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       run_q, cont_q;
  logic       run_rise, cont_rise;
  logic       pause_here;

  assign run_rise  = bus.Run & ~run_q;
  assign cont_rise = bus.Continue & ~cont_q;

  // IR is already loaded when PAUSE1 is entered, so Opcode is a stable register value here.
  assign pause_here = PAUSE_EVERY || (bus.Opcode == OP_PAUSE);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
      run_q    <= 1'b0;
      cont_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      run_q    <= bus.Run;
      cont_q   <= bus.Continue;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case, so no path infers a latch.
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = 2'b00;
    bus.MIO_EN     = 1'b0;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;

    unique case (state)
      HALTED: begin
        if (run_rise) state_nxt = S18;
      end
      S18: begin
        bus.GatePC   = 1'b1;
        bus.LD_MAR   = 1'b1;
        bus.LD_PC    = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = S33;
      end
      S33: begin
        bus.Mem_OE   = 1'b0;
        bus.MIO_EN   = 1'b1;
        // Cleared in S18 and left at WAIT_LAST <= 14, so this never wraps.
        wait_cnt_nxt = wait_cnt + 4'd1;
        if (wait_cnt == WAIT_LAST) begin
          bus.LD_MDR = 1'b1;
          state_nxt  = S35;
        end
      end
      S35: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
        state_nxt   = PAUSE1;
      end
      PAUSE1: begin
        if (!pause_here) begin
          state_nxt = S18;
        end else begin
          bus.LD_LED = 1'b1;
          if (cont_rise) state_nxt = PAUSE2;
        end
      end
      PAUSE2: begin
        bus.LD_LED = 1'b1;
        // Wait for release so one press advances exactly one instruction.
        if (!bus.Continue) state_nxt = S18;
      end
      default: begin
        state_nxt = HALTED;
      end
    endcase
  end

  assign bus.State_o = state;

endmodule

// File: tb/tb_slc3_fetch_ctrl.sv
// Bench for slc3_fetch_ctrl: a small datapath/SRAM model around the DUT, a
// fetch-sequence reference model feeding a scoreboard, and a negedge monitor.
module tb_slc3_fetch_ctrl;

  localparam int         MEM_WAIT = 2;
  localparam logic [3:0] OP_PAUSE = 4'hD;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  slc3_fetch_ctrl_if ifc ();

  slc3_fetch_ctrl #(
    .MEM_WAIT    (MEM_WAIT),
    .PAUSE_EVERY (1'b0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifc)
  );

  always #5 Clk = ~Clk;

  // Datapath and SRAM environment reacting to the DUT's control outputs.
  logic [15:0] mem [256];
  logic [15:0] pc, mar, mdr, ir, dbus;
  logic [9:0]  led;

  always_comb begin
    dbus = 16'h0000;
    if (ifc.GatePC)       dbus = pc;
    else if (ifc.GateMDR) dbus = mdr;
  end

  assign ifc.Opcode = ir[15:12];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc  <= 16'h0000;
      mar <= 16'h0000;
      mdr <= 16'h0000;
      ir  <= 16'h0000;
      led <= 10'h000;
    end else begin
      if (ifc.LD_MAR) mar <= dbus;
      if (ifc.LD_PC)  pc  <= pc + 16'h0001;
      if (ifc.LD_MDR) mdr <= (ifc.MIO_EN && !ifc.Mem_OE) ? mem[mar[7:0]] : dbus;
      if (ifc.LD_IR)  ir  <= dbus;
      if (ifc.LD_LED) led <= ir[9:0];
    end
  end

  // Scoreboard: an entry per instruction fetched, plus one per expected pause.
  typedef struct {
    bit          is_pause;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks    = 0;
  int          n_fail      = 0;
  int          pauses_seen = 0;
  logic [15:0] model_pc;
  bit          run_rand    = 1'b0;
  int          exp_seq [11] = '{1, 2, 2, 3, 4, 1, 2, 2, 3, 4, 4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: fetch sequentially from model_pc until an opcode-D
  // instruction, which leaves the machine paused showing its low 10 bits.
  task automatic push_run();
    exp_t        e;
    logic [15:0] w;
    for (int k = 0; k < 16; k++) begin
      w          = mem[model_pc[7:0]];
      e.is_pause = 1'b0;
      e.addr     = model_pc;
      e.data     = w;
      exp_q.push_back(e);
      model_pc   = model_pc + 16'h0001;
      if (w[15:12] == OP_PAUSE) begin
        e.is_pause = 1'b1;
        exp_q.push_back(e);
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (run_rand) ifc.Run = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_pause(input string name);
    int target;
    int n;
    target = pauses_seen + 1;
    n      = 0;
    while (pauses_seen < target && n < 300) begin
      tick();
      n++;
    end
    check({name, "_reached"}, 32'(pauses_seen >= target), 32'd1);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic step(input int hold);
    ifc.Continue = 1'b1;
    push_run();
    for (int i = 0; i < hold; i++) begin
      tick();
      check("pause2_hold", 32'(ifc.State_o), 32'd5);
    end
    ifc.Continue = 1'b0;
    tick();
    check("resume_s18", 32'(ifc.State_o), 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_state"}, 32'(ifc.State_o), 32'd0);
    check({name, "_loads"}, 32'({ifc.LD_MAR, ifc.LD_MDR, ifc.LD_IR, ifc.LD_PC, ifc.LD_LED}), 32'd0);
    check({name, "_gates"}, 32'({ifc.GatePC, ifc.GateMDR, ifc.GateALU, ifc.GateMARMUX}), 32'd0);
    check({name, "_mem"}, 32'({ifc.Mem_OE, ifc.Mem_WE, ifc.MIO_EN}), 32'b110);
  endtask

  // Monitor: samples on the falling edge what the next rising edge will do.
  initial begin
    int          cyc_since_mar;
    bit          prev_led;
    bit          led_due;
    logic [9:0]  led_exp;
    int          gates;
    exp_t        e;
    cyc_since_mar = 0;
    prev_led      = 1'b0;
    led_due       = 1'b0;
    led_exp       = '0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        cyc_since_mar = 0;
        prev_led      = 1'b0;
        led_due       = 1'b0;
      end else begin
        gates = int'(ifc.GatePC) + int'(ifc.GateMDR) + int'(ifc.GateALU) + int'(ifc.GateMARMUX);
        check("bus_rules", 32'(gates <= 1 && ifc.Mem_WE === 1'b1 && ifc.PCMUX === 2'b00
                               && ifc.GateALU === 1'b0 && ifc.GateMARMUX === 1'b0), 32'd1);
        if (led_due) begin
          check("led_value", 32'(led), 32'(led_exp));
          led_due = 1'b0;
        end
        cyc_since_mar = ifc.LD_MAR ? 0 : cyc_since_mar + 1;
        if (ifc.LD_MDR) begin
          check("mdr_latency", 32'(cyc_since_mar), 32'(MEM_WAIT));
          check("mdr_from_mem", 32'({ifc.Mem_OE, ifc.MIO_EN}), 32'b01);
        end
        if (ifc.LD_IR) begin
          check("ir_latency", 32'(cyc_since_mar), 32'(MEM_WAIT + 1));
          check("fetch_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("fetch_kind", 32'(e.is_pause), 32'd0);
            check("fetch_addr", 32'(mar), 32'(e.addr));
            check("fetch_data", 32'(dbus), 32'(e.data));
            check("pc_after_fetch", 32'(pc), 32'(16'(e.addr + 16'h0001)));
          end
        end
        if (ifc.LD_LED && !prev_led) begin
          check("pause_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pause_kind", 32'(e.is_pause), 32'd1);
            check("pause_ir", 32'(ir), 32'(e.data));
            led_exp = e.data[9:0];
            led_due = 1'b1;
          end
          pauses_seen++;
        end
        prev_led = ifc.LD_LED;
      end
    end
  end

  initial begin
    logic [15:0] w;
    ifc.Run      = 1'b0;
    ifc.Continue = 1'b0;
    model_pc     = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ((i % 8) == 7 || $urandom_range(0, 3) == 0) w[15:12] = OP_PAUSE;
      else if (w[15:12] == OP_PAUSE)                 w[15:12] = 4'h0;
      mem[i] = w;
    end
    mem[0] = 16'h1234;
    mem[1] = 16'hD005;

    #2 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_idle_outputs("reset");

    Reset = 1'b1;
    tick();
    tick();
    check("idle_halted", 32'(ifc.State_o), 32'd0);

    // Run and Continue rise together in HALTED: Run starts, Continue ignored.
    push_run();
    ifc.Run      = 1'b1;
    ifc.Continue = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 0) begin
        ifc.Run      = 1'b0;
        ifc.Continue = 1'b0;
      end
      check("timeline", 32'(ifc.State_o), 32'(exp_seq[i]));
    end
    check("first_pause_count", 32'(pauses_seen), 32'd1);

    step(10);
    wait_pause("step_held10");

    run_rand = 1'b1;
    repeat (6) begin
      step($urandom_range(1, 4));
      wait_pause("rand_step");
    end

    // Abort a fetch during the SRAM wait.
    step(2);
    tick();
    check("in_s33", 32'(ifc.State_o), 32'd2);
    #2 Reset = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    exp_q.delete();
    model_pc = 16'h0000;
    run_rand = 1'b0;
    ifc.Run  = 1'b1;
    tick();
    tick();
    check("reset_hold_halted", 32'(ifc.State_o), 32'd0);

    // Run held high across reset release: exactly one start.
    push_run();
    Reset = 1'b1;
    wait_pause("run_held_start");
    step(3);
    wait_pause("run_held_step");
    step(1);
    wait_pause("run_held_step2");

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
